flick_scheduler: RTL and testbench

- Shares one bound_flasher instance between N_REQ requesters.
- Arbitrates round-robin among pending requests and issues a bounded flick pulse only when the flasher is idle (LEDs all off).
- Monitors the LEDs bus to detect when the run completes, then acks the winner.
- Sits between the request sources and the flasher's flick input; observes the flasher's LEDs output.

---
 rtl/flick_sched_pkg.sv | 9 +
 rtl/flick_scheduler_rr_arbiter.sv | 28 ++
 rtl/flick_scheduler.sv | 133 +++++++++++++
 tb/tb_flick_scheduler.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/flick_sched_pkg.sv
// Shared types and constants for the flick scheduler and bound_flasher benches.
package flick_sched_pkg;

  typedef enum logic [2:0] {IDLE, FLICK, RUN, DONE, GAP} sched_state_t;

  localparam int LED_W = 16;
  localparam logic [LED_W-1:0] LEDS_OFF = '0;

endpackage

// File: rtl/flick_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first pending request at or after
// rr_ptr (wrapping) wins, reported one-hot together with a valid flag.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  logic [PW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = PW'((int'(rr_ptr) + off) % N_REQ);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flick_scheduler.sv
// Shares one bound_flasher between N_REQ requesters: round-robin grant, a
// bounded flick pulse while the LEDs are dark, then ack when the run ends.
module flick_scheduler
  import flick_sched_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int FLICK_CYCLES = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [LED_W-1:0] leds,
  output logic             flick,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] ack,
  output logic             busy,
  output logic             timeout_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX    = CW'(TIMEOUT);
  localparam logic [CW-1:0] FC_LAST = CW'(FLICK_CYCLES - 1);

  sched_state_t     state, state_n;
  logic [PW-1:0]    rr_ptr, ptr_n, ptr_adv;
  logic [CW-1:0]    cyc_cnt, cnt_n;
  logic             started, started_n;
  logic             abort, abort_n;
  logic             flick_n, terr_n, leds_on;
  logic [N_REQ-1:0] grant_n, ack_n;
  logic [N_REQ-1:0] win_onehot;
  logic             win_valid;

  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (win_onehot),
    .valid  (win_valid)
  );

  always_comb begin
    ptr_adv = rr_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) ptr_adv = (i == N_REQ - 1) ? '0 : PW'(i + 1);
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n   = state;
    flick_n   = 1'b0;
    grant_n   = grant;
    ack_n     = '0;
    terr_n    = 1'b0;
    ptr_n     = rr_ptr;
    cnt_n     = cyc_cnt;
    started_n = started;
    abort_n   = abort;
    leds_on   = (leds != LEDS_OFF);

    if (state == FLICK || state == RUN) begin
      if (cyc_cnt != TMAX) cnt_n = cyc_cnt + 1'b1;
      if (leds_on) started_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (!leds_on && win_valid) begin
          state_n   = FLICK;
          flick_n   = 1'b1;
          grant_n   = win_onehot;
          cnt_n     = '0;
          started_n = 1'b0;
          abort_n   = 1'b0;
        end
      end
      FLICK: begin
        if (cyc_cnt == FC_LAST) state_n = RUN;
        else                    flick_n = 1'b1;
      end
      RUN: begin
        if (started && !leds_on) begin
          state_n = DONE;
        end else if (cyc_cnt == TMAX) begin
          state_n = DONE;
          abort_n = 1'b1;
        end
      end
      DONE: begin
        state_n = GAP;
        grant_n = '0;
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Ack, abort flag and pointer advance all land on the edge entering DONE.
    if (state != DONE && state_n == DONE) begin
      ack_n  = grant;
      terr_n = abort_n;
      ptr_n  = ptr_adv;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      flick       <= 1'b0;
      grant       <= '0;
      ack         <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      cyc_cnt     <= '0;
      started     <= 1'b0;
      abort       <= 1'b0;
    end else begin
      state       <= state_n;
      flick       <= flick_n;
      grant       <= grant_n;
      ack         <= ack_n;
      busy        <= (state_n != IDLE);
      timeout_err <= terr_n;
      rr_ptr      <= ptr_n;
      cyc_cnt     <= cnt_n;
      started     <= started_n;
      abort       <= abort_n;
    end
  end

endmodule

// File: tb/tb_flick_scheduler.sv
// Directed bench for flick_scheduler with a hand-modelled flasher on the LEDs bus.
module tb_flick_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] leds = '0;
  logic        flick;
  logic [3:0]  grant, ack;
  logic        busy, timeout_err;

  int checks = 0;
  int failures = 0;

  flick_scheduler #(.N_REQ(4), .FLICK_CYCLES(2), .TIMEOUT(255)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .leds        (leds),
    .flick       (flick),
    .grant       (grant),
    .ack         (ack),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [15:0] l);
    req  = r;
    leds = l;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_flick"}, 32'(flick), 32'd0);
    checkOutput({tag, "_grant"}, 32'(grant), 32'd0);
    checkOutput({tag, "_ack"}, 32'(ack), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_terr"}, 32'(timeout_err), 32'd0);
  endtask

  // Called in IDLE with leds dark and req set; the next edge must arbitrate.
  task automatic serveRun(input logic [3:0] exp_grant, input int run_len,
                          input logic [15:0] pat, input logic exp_to,
                          input logic drop_mid);
    tick();
    checkOutput("flick_rise", 32'(flick), 32'd1);
    checkOutput("grant", 32'(grant), 32'(exp_grant));
    checkOutput("busy_run", 32'(busy), 32'd1);
    tick();
    checkOutput("flick_hold", 32'(flick), 32'd1);
    tick();
    checkOutput("flick_fall", 32'(flick), 32'd0);
    checkOutput("grant_held", 32'(grant), 32'(exp_grant));
    if (drop_mid) req = '0;
    leds = pat;
    repeat (run_len) tick();
    leds = '0;
    checkOutput("no_early_ack", 32'(ack), 32'd0);
    tick();
    checkOutput("ack", 32'(ack), 32'(exp_grant));
    checkOutput("timeout_err", 32'(timeout_err), 32'(exp_to));
    req = req & ~exp_grant;
    tick();
    checkOutput("ack_pulse", 32'(ack), 32'd0);
    checkOutput("terr_pulse", 32'(timeout_err), 32'd0);
    checkOutput("grant_clear", 32'(grant), 32'd0);
    checkOutput("busy_gap", 32'(busy), 32'd1);
    tick();
    checkOutput("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b0;
    applyStimulus(4'b0000, 16'h0000);
    #1;
    checkIdleOutputs("reset");
    tick();
    tick();
    rst = 1'b1;
  endtask

  logic [3:0] rr_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    #2;
    doReset();

    // single requester, 51-clock flasher run
    applyStimulus(4'b0001, 16'h0000);
    serveRun(4'b0001, 51, 16'h0001, 1'b0, 1'b0);

    // all requesting: strict rotation starting from pointer 0
    doReset();
    applyStimulus(4'b1111, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      serveRun(rr_order[k], 5, 16'h8001, 1'b0, 1'b0);
      req = req | rr_order[k];
    end

    // flasher still lit: no flick until leds go dark
    applyStimulus(4'b0010, 16'h001F);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("lit_no_flick", 32'(flick), 32'd0);
      checkOutput("lit_not_busy", 32'(busy), 32'd0);
    end
    leds = '0;
    serveRun(4'b0010, 4, 16'h0003, 1'b0, 1'b0);

    // dead flasher: abort at the timeout, then the next request is served
    applyStimulus(4'b0100, 16'h0000);
    serveRun(4'b0100, 253, 16'h0000, 1'b1, 1'b0);
    applyStimulus(4'b0001, 16'h0000);
    serveRun(4'b0001, 4, 16'h0010, 1'b0, 1'b0);

    // reset in the middle of a run
    applyStimulus(4'b1000, 16'h0000);
    tick();
    checkOutput("pre_reset_grant", 32'(grant), 32'h8);
    tick();
    tick();
    leds = 16'h03FF;
    repeat (5) tick();
    #2;
    rst = 1'b0;
    applyStimulus(4'b0000, 16'h0000);
    #1;
    checkIdleOutputs("midrun_reset");
    tick();
    checkIdleOutputs("held_reset");
    rst = 1'b1;
    applyStimulus(4'b0100, 16'h0000);
    serveRun(4'b0100, 6, 16'h03FF, 1'b0, 1'b0);

    // requester withdraws mid-run: run still completes and acks once
    applyStimulus(4'b0001, 16'h0000);
    serveRun(4'b0001, 7, 16'h0040, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("withdrawn_no_flick", 32'(flick), 32'd0);
      checkOutput("withdrawn_idle", 32'(busy), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
